// File: rtl/video_pkg.sv
// Shared video-path types: display-gating FSM states, tag bit positions and
// RGB444 palette word field positions.
package video_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARM      = 2'd1,
    ACTIVE   = 2'd2,
    DRAIN    = 2'd3
  } disp_state_t;

  localparam int TAG_VSYNC = 2;
  localparam int TAG_HSYNC = 1;
  localparam int TAG_BLANK = 0;

  localparam int PAL_R_MSB = 11;
  localparam int PAL_R_LSB = 8;
  localparam int PAL_G_MSB = 7;
  localparam int PAL_G_LSB = 4;
  localparam int PAL_B_MSB = 3;
  localparam int PAL_B_LSB = 0;

  // Colour is shown while the display is running or draining to the frame edge.
  function automatic logic state_shows(input disp_state_t s);
    return (s == ACTIVE) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/palette_lookup_if.sv
// Pixel-stream, palette-RAM read port and expanded-colour output signals of
// the palette lookup stage.
interface palette_lookup_if #(parameter int OUT_BITS = 8);

  logic                pix_valid_i;
  logic [7:0]          pix_index_i;
  logic                pix_border_i;
  logic [2:0]          pix_tags_i;
  logic [7:0]          border_idx_i;
  logic                disp_en_i;
  logic                pal_rd_en_o;
  logic [7:0]          pal_rd_addr_o;
  logic [15:0]         pal_rd_data_i;
  logic                rgb_valid_o;
  logic [OUT_BITS-1:0] r_o;
  logic [OUT_BITS-1:0] g_o;
  logic [OUT_BITS-1:0] b_o;
  logic [2:0]          tags_o;
  logic                disp_active_o;

  modport master (
    output pix_valid_i, pix_index_i, pix_border_i, pix_tags_i,
    output border_idx_i, disp_en_i, pal_rd_data_i,
    input  pal_rd_en_o, pal_rd_addr_o,
    input  rgb_valid_o, r_o, g_o, b_o, tags_o, disp_active_o
  );

  modport slave (
    input  pix_valid_i, pix_index_i, pix_border_i, pix_tags_i,
    input  border_idx_i, disp_en_i, pal_rd_data_i,
    output pal_rd_en_o, pal_rd_addr_o,
    output rgb_valid_o, r_o, g_o, b_o, tags_o, disp_active_o
  );

endinterface

// File: rtl/rgb444_expand.sv
// Expands one 4-bit colour channel to OUT_BITS by nibble replication,
// keeping the most significant bits.
module rgb444_expand #(
  parameter int OUT_BITS = 8
) (
  input  logic [3:0]          c4,
  output logic [OUT_BITS-1:0] c_out
);

  logic [7:0] rep_s;

  assign rep_s = {c4, c4};
  assign c_out = rep_s[7 -: OUT_BITS];

endmodule

// File: rtl/palette_lookup.sv
// Palette lookup stage: drives the palette RAM read port, aligns tags with the
// registered RAM data, expands RGB444 and gates the display at frame edges.
module palette_lookup
  import video_pkg::*;
#(
  parameter int OUT_BITS  = 8,
  parameter int PIPE_TAGS = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  palette_lookup_if.slave  pl
);

  disp_state_t             state_r;
  disp_state_t             state_next_s;
  logic                    prev_vsync_r;
  logic                    frame_edge_s;
  logic                    disp_active_r;

  logic                    s1_valid_r;
  logic [PIPE_TAGS-1:0]    s1_tags_r;
  logic                    s1_show_r;

  logic                    rgb_valid_r;
  logic [PIPE_TAGS-1:0]    tags_r;
  logic [OUT_BITS-1:0]     r_r;
  logic [OUT_BITS-1:0]     g_r;
  logic [OUT_BITS-1:0]     b_r;

  logic [OUT_BITS-1:0]     r_exp_s;
  logic [OUT_BITS-1:0]     g_exp_s;
  logic [OUT_BITS-1:0]     b_exp_s;
  logic                    unused_s;

  assign pl.pal_rd_addr_o = pl.pix_border_i ? pl.border_idx_i : pl.pix_index_i;
  assign pl.pal_rd_en_o   = pl.pix_valid_i;

  // Only valid pixels update the vsync history, so bubbles never create edges.
  assign frame_edge_s = pl.pix_valid_i & pl.pix_tags_i[TAG_VSYNC] & ~prev_vsync_r;

  // Display gating next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      DISABLED: begin
        if (pl.disp_en_i) state_next_s = ARM;
        else              state_next_s = DISABLED;
      end
      ARM: begin
        if (!pl.disp_en_i)     state_next_s = DISABLED;
        else if (frame_edge_s) state_next_s = ACTIVE;
        else                   state_next_s = ARM;
      end
      ACTIVE: begin
        if (!pl.disp_en_i) state_next_s = DRAIN;
        else               state_next_s = ACTIVE;
      end
      DRAIN: begin
        if (pl.disp_en_i)      state_next_s = ACTIVE;
        else if (frame_edge_s) state_next_s = DISABLED;
        else                   state_next_s = DRAIN;
      end
      default: state_next_s = DISABLED;
    endcase
  end

  // FSM state, vsync history and display-active flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r       <= DISABLED;
      prev_vsync_r  <= 1'b0;
      disp_active_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      disp_active_r <= state_shows(state_next_s);
      if (pl.pix_valid_i) prev_vsync_r <= pl.pix_tags_i[TAG_VSYNC];
      else                prev_vsync_r <= prev_vsync_r;
    end
  end

  // Stage 1: carry valid, tags and the current gating decision beside the RAM read
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_r <= 1'b0;
      s1_tags_r  <= {PIPE_TAGS{1'b0}};
      s1_show_r  <= 1'b0;
    end else begin
      s1_valid_r <= pl.pix_valid_i;
      s1_tags_r  <= pl.pix_tags_i;
      s1_show_r  <= state_shows(state_r);
    end
  end

  rgb444_expand #(.OUT_BITS(OUT_BITS)) u_exp_r (
    .c4    (pl.pal_rd_data_i[PAL_R_MSB:PAL_R_LSB]),
    .c_out (r_exp_s)
  );
  rgb444_expand #(.OUT_BITS(OUT_BITS)) u_exp_g (
    .c4    (pl.pal_rd_data_i[PAL_G_MSB:PAL_G_LSB]),
    .c_out (g_exp_s)
  );
  rgb444_expand #(.OUT_BITS(OUT_BITS)) u_exp_b (
    .c4    (pl.pal_rd_data_i[PAL_B_MSB:PAL_B_LSB]),
    .c_out (b_exp_s)
  );

  assign unused_s = ^pl.pal_rd_data_i[15:12];

  // Stage 2: output registers; bubbles leave colour and tags unchanged
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_valid_r <= 1'b0;
      tags_r      <= {PIPE_TAGS{1'b0}};
      r_r         <= {OUT_BITS{1'b0}};
      g_r         <= {OUT_BITS{1'b0}};
      b_r         <= {OUT_BITS{1'b0}};
    end else begin
      rgb_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        tags_r <= s1_tags_r;
        if (s1_tags_r[TAG_BLANK] || !s1_show_r) begin
          r_r <= {OUT_BITS{1'b0}};
          g_r <= {OUT_BITS{1'b0}};
          b_r <= {OUT_BITS{1'b0}};
        end else begin
          r_r <= r_exp_s;
          g_r <= g_exp_s;
          b_r <= b_exp_s;
        end
      end else begin
        tags_r <= tags_r;
        r_r    <= r_r;
        g_r    <= g_r;
        b_r    <= b_r;
      end
    end
  end

  assign pl.rgb_valid_o   = rgb_valid_r;
  assign pl.tags_o        = tags_r;
  assign pl.r_o           = r_r;
  assign pl.g_o           = g_r;
  assign pl.b_o           = b_r;
  assign pl.disp_active_o = disp_active_r;

endmodule

// File: tb/tb_palette_lookup.sv
// Directed bench for palette_lookup: 1-cycle registered palette RAM model and a
// two-deep expectation pipe matching the fixed output latency.
module tb_palette_lookup;

  logic clk_i;
  logic rst_n_i;

  palette_lookup_if #(.OUT_BITS(8)) bus ();

  palette_lookup #(.OUT_BITS(8), .PIPE_TAGS(3)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .pl      (bus)
  );

  logic [15:0] pal_mem [256];

  int err_cnt = 0;
  int chk_cnt = 0;

  logic        p_chk [2];
  logic        p_val [2];
  logic [23:0] p_rgb [2];
  logic [2:0]  p_tg  [2];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (bus.pal_rd_en_o) bus.pal_rd_data_i <= pal_mem[bus.pal_rd_addr_o];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One pixel slot: check outputs due now, then drive this pixel.
  task automatic step(input logic v, input logic [7:0] idx, input logic brd,
                      input logic [2:0] tg, input logic en, input logic act,
                      input logic chk, input logic ev, input logic [23:0] ergb,
                      input logic [2:0] etg, input logic [7:0] eaddr);
    @(negedge clk_i);
    if (p_chk[1]) begin
      check_val("rgb_valid", {31'd0, bus.rgb_valid_o}, {31'd0, p_val[1]});
      check_val("rgb", {8'd0, bus.r_o, bus.g_o, bus.b_o}, {8'd0, p_rgb[1]});
      check_val("tags", {29'd0, bus.tags_o}, {29'd0, p_tg[1]});
    end
    check_val("disp_active", {31'd0, bus.disp_active_o}, {31'd0, act});
    p_chk[1] = p_chk[0]; p_val[1] = p_val[0]; p_rgb[1] = p_rgb[0]; p_tg[1] = p_tg[0];
    p_chk[0] = chk;      p_val[0] = ev;       p_rgb[0] = ergb;     p_tg[0] = etg;
    bus.pix_valid_i  = v;
    bus.pix_index_i  = idx;
    bus.pix_border_i = brd;
    bus.pix_tags_i   = tg;
    bus.disp_en_i    = en;
    #1;
    check_val("rd_addr", {24'd0, bus.pal_rd_addr_o}, {24'd0, eaddr});
    check_val("rd_en", {31'd0, bus.pal_rd_en_o}, {31'd0, v});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pal_mem[i] = 16'h0000;
    pal_mem[8'h12] = 16'h0ABC;
    pal_mem[8'h05] = 16'h0F00;
    pal_mem[8'h30] = 16'hF123;
    for (int i = 0; i < 2; i++) begin
      p_chk[i] = 1'b0; p_val[i] = 1'b0; p_rgb[i] = 24'd0; p_tg[i] = 3'd0;
    end

    rst_n_i          = 1'b0;
    bus.pix_valid_i  = 1'b0;
    bus.pix_index_i  = 8'h00;
    bus.pix_border_i = 1'b0;
    bus.pix_tags_i   = 3'b000;
    bus.border_idx_i = 8'h05;
    bus.disp_en_i    = 1'b0;
    #3;
    check_val("rst_rgb_valid", {31'd0, bus.rgb_valid_o}, 32'd0);
    check_val("rst_rgb", {8'd0, bus.r_o, bus.g_o, bus.b_o}, 32'd0);
    check_val("rst_tags", {29'd0, bus.tags_o}, 32'd0);
    check_val("rst_disp_active", {31'd0, bus.disp_active_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    //   v    idx   brd tags    en  act chk ev  rgb         etags   addr
    // enable mid-frame: ARM until the vsync rise, colour from the pixel after it
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b000, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b000, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b100, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 3'b100, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 3'b000, 8'h12);
    // border colour, blank forcing, ignored top nibble, bubble 1,0,1 with hold
    step(1'b1, 8'h12, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFF0000, 3'b000, 8'h05);
    step(1'b1, 8'h12, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000000, 3'b001, 8'h12);
    step(1'b1, 8'h30, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 24'h112233, 3'b000, 8'h30);
    step(1'b0, 8'h30, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 24'h112233, 3'b000, 8'h30);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 3'b000, 8'h12);
    // disable: colour continues through the vsync-edge pixel, then black
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 3'b000, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 3'b000, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 3'b100, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b100, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b000, 8'h12);
    // enable on the vsync-edge cycle: ARM only, colour after the following edge
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b100, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b100, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b000, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b100, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 3'b100, 8'h12);
    step(1'b0, 8'h12, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b000, 8'h12);
    step(1'b0, 8'h12, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b000, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b000, 8'h12);
    step(1'b1, 8'h12, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b000, 8'h12);

    // asynchronous reset mid-line while a coloured pixel sits on the outputs
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_val("arst_rgb_valid", {31'd0, bus.rgb_valid_o}, 32'd0);
    check_val("arst_rgb", {8'd0, bus.r_o, bus.g_o, bus.b_o}, 32'd0);
    check_val("arst_tags", {29'd0, bus.tags_o}, 32'd0);
    check_val("arst_disp_active", {31'd0, bus.disp_active_o}, 32'd0);
    @(negedge clk_i);
    bus.disp_en_i   = 1'b0;
    bus.pix_valid_i = 1'b0;
    rst_n_i         = 1'b1;
    repeat (3) @(negedge clk_i);
    check_val("post_rst_disp_active", {31'd0, bus.disp_active_o}, 32'd0);
    check_val("post_rst_rgb_valid", {31'd0, bus.rgb_valid_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
